// File: rtl/mul_add.sv
// mul_add: sequential shift-add multiply-accumulate, prod = mcand*mplr + addend.
// Companion of the restoring divider: driving mcand=divisor, mplr=quotient and
// addend=remainder reproduces the dividend. One multiply iteration per clock.
// Optional build macro: MUL_ADD_RMD_CHECK_EN adds the rmd_err output, which flags
// an invalid remainder (addend >= mcand) captured with the operands.
module mul_add #(
    parameter int w  = 4,   // operand width, w >= 2
    parameter int c1 = 3    // iteration-counter width, must hold the value w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [w-1:0]     mcand,
    input  logic [w-1:0]     mplr,
    input  logic [w-1:0]     addend,
    output logic             ready,
    output logic             done,
    output logic [2*w-1:0]   prod
`ifdef MUL_ADD_RMD_CHECK_EN
    ,
    output logic             rmd_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2*w-1:0]       acc_q, acc_d;    // {hi, lo}; lo starts as the multiplier
    logic [c1-1:0]        n_q, n_d;        // iterations still to run
    logic [w-1:0]         mc_q, mc_d;      // captured multiplicand
    logic [w-1:0]         ad_q, ad_d;      // captured addend
`ifdef MUL_ADD_RMD_CHECK_EN
    logic                 rmd_q, rmd_d;
`endif

    // One shift-add step: conditionally add the multiplicand into the high half
    // (carry kept in the extra bit), then shift the whole {carry,hi,lo} right by one.
    function automatic logic [2*w-1:0] mul_step(input logic [2*w-1:0] acc,
                                                input logic [w-1:0]   mc);
        logic [w:0] s;
        if (acc[0]) begin
            s = {1'b0, acc[2*w-1:w]} + {1'b0, mc};
        end else begin
            s = {1'b0, acc[2*w-1:w]};
        end
        return {s, acc[w-1:1]};
    endfunction

    // Final accumulate of the zero-extended addend; cannot overflow 2w bits
    // because (2^w-1)^2 + (2^w-1) < 2^(2w).
    function automatic logic [2*w-1:0] add_tail(input logic [2*w-1:0] acc,
                                                input logic [w-1:0]   ad);
        return acc + {{w{1'b0}}, ad};
    endfunction

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        n_d     = n_q;
        mc_d    = mc_q;
        ad_d    = ad_q;
`ifdef MUL_ADD_RMD_CHECK_EN
        rmd_d   = rmd_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = {{w{1'b0}}, mplr};
                    mc_d    = mcand;
                    ad_d    = addend;
                    n_d     = c1'(w);
`ifdef MUL_ADD_RMD_CHECK_EN
                    rmd_d   = (addend >= mcand);
`endif
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = mul_step(acc_q, mc_q);
                n_d   = n_q - c1'(1);
                if (n_q == c1'(1)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                acc_d   = add_tail(acc_q, ad_q);
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and accumulator; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
        end
    end

    // Captured operands; only read after a fresh capture, so no reset needed.
    always_ff @(posedge clk) begin
        mc_q <= mc_d;
        ad_q <= ad_d;
    end

`ifdef MUL_ADD_RMD_CHECK_EN
    // Invalid-remainder flag, held until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rmd_q <= 1'b0;
        end else begin
            rmd_q <= rmd_d;
        end
    end

    assign rmd_err = rmd_q;
`endif

    assign ready = (state_q == IDLE);
    assign done  = (state_q == FIN);
    assign prod  = acc_q;

endmodule

// File: tb/tb_mul_add.sv
// Bench for mul_add (w=4): reference model tracks the operation as a countdown
// of cycles and the arithmetic result; directed cases pin literal results.
module tb_mul_add;

    localparam int W  = 4;
    localparam int C1 = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplr = '0;
    logic [W-1:0]   addend = '0;
    logic           ready;
    logic           done;
    logic [2*W-1:0] prod;
`ifdef MUL_ADD_RMD_CHECK_EN
    logic           rmd_err;
`endif

    mul_add #(.w(W), .c1(C1)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mcand  (mcand),
        .mplr   (mplr),
        .addend (addend),
        .ready  (ready),
        .done   (done),
        .prod   (prod)
`ifdef MUL_ADD_RMD_CHECK_EN
        ,
        .rmd_err(rmd_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: m_cnt counts cycles left in the operation (0 = idle,
    // 1 = result cycle); m_prod is the last result, m_rmd the last flag.
    int          m_cnt  = 0;
    int unsigned m_prod = 0;
    logic        m_rmd  = 1'b0;

    int          lit_req = 0;
    int          lit_seen = 0;
    int unsigned lit_prod = 0;
    logic        lit_rmd = 1'b0;
    int          to_req = 0;
    int          to_seen = 0;
    int          done_cnt = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  = 0;
            m_prod = 0;
            m_rmd  = 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt = m_cnt - 1;
        end else if (start) begin
            m_cnt  = W + 2;
            m_prod = int'(mcand) * int'(mplr) + int'(addend);
            m_rmd  = (addend >= mcand);
        end
    end

    always begin
        @(negedge clk or posedge rst);
        if (rst) begin
            #1;
            chk("rst_prod", prod, 0);
            chk("rst_ready", ready, 1);
            chk("rst_done", done, 0);
`ifdef MUL_ADD_RMD_CHECK_EN
            chk("rst_rmd", rmd_err, 0);
`endif
        end else begin
            chk("ready", ready, (m_cnt == 0) ? 1 : 0);
            chk("done", done, (m_cnt == 1) ? 1 : 0);
            if (m_cnt <= 1) chk("prod", prod, m_prod);
`ifdef MUL_ADD_RMD_CHECK_EN
            chk("rmd_err", rmd_err, m_rmd);
`endif
            if (done) done_cnt++;
            if (done && lit_req != lit_seen) begin
                chk("lit_prod", prod, lit_prod);
`ifdef MUL_ADD_RMD_CHECK_EN
                chk("lit_rmd", rmd_err, lit_rmd);
`endif
                lit_seen = lit_req;
            end
            if (to_req != to_seen) begin
                total++;
                bad++;
                $display("FAIL timeout: no done within bound at %0t (got none, required one)", $time);
                to_seen = to_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!ready && k < 30) begin
            tick();
            k++;
        end
        if (k >= 30) to_req++;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input int unsigned ep, input logic er);
        int k = 0;
        wait_idle();
        lit_prod = ep;
        lit_rmd  = er;
        lit_req++;
        mcand  = a;
        mplr   = b;
        addend = c;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        mcand  = W'($urandom);
        mplr   = W'($urandom);
        addend = W'($urandom);
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) to_req++;
        tick();
    endtask

    initial begin
        int d0;
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_op(4'd3, 4'd5, 4'd2, 32'h11, 1'b0);
        run_op(4'd15, 4'd15, 4'd15, 32'hF0, 1'b1);
        run_op(4'd0, 4'd9, 4'd6, 32'h06, 1'b1);
        run_op(4'd5, 4'd0, 4'd3, 32'h03, 1'b0);

        // Abort during the multiply phase of 9*9+0.
        wait_idle();
        mcand = 4'd9; mplr = 4'd9; addend = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        run_op(4'd7, 4'd2, 4'd1, 32'h0F, 1'b0);

        run_op(4'd4, 4'd3, 4'd4, 32'h10, 1'b1);
        run_op(4'd4, 4'd3, 4'd3, 32'h0F, 1'b0);

        // Start held high: operations relaunch back to back, inputs change freely.
        wait_idle();
        d0 = done_cnt;
        start = 1'b1;
        for (int i = 0; i < 70; i++) begin
            mcand  = W'($urandom);
            mplr   = W'($urandom);
            addend = W'($urandom);
            tick();
        end
        start = 1'b0;
        wait_idle();
        chk("held_start_dones", done_cnt - d0, 10);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            start  = ($urandom_range(0, 2) == 0);
            mcand  = W'($urandom);
            mplr   = W'($urandom);
            addend = W'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        start = 1'b0;
        wait_idle();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
